// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Brief    : Shared constants for the seven-segment scan path. The digit
//            count is common to the scanner and the hex-to-segment converter.
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Number of physical display digits on the board
    localparam int SEG_DIGITS = 4;

    // Board clock and per-digit slot rate used to derive the scan divider
    localparam int BOARD_CLK_HZ = 50_000_000;
    localparam int SCAN_SLOT_HZ = 1_000;
    localparam int SEG_SCAN_DIV = BOARD_CLK_HZ / SCAN_SLOT_HZ;

    // Level that turns a digit on; the display anodes are driven low-active
    localparam logic DIG_ACTIVE_LEVEL = 1'b0;

    // Index width for a counter over n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_prescaler
// Brief    : Terminal-count divider. Counts 0..TERMINAL-1 and wraps; o_tick
//            is high for the single cycle the count sits at TERMINAL-1.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int                c_DIV_W = idx_width(TERMINAL);
    localparam logic [c_DIV_W-1:0] c_LAST  = c_DIV_W'(TERMINAL - 1);

    logic [c_DIV_W-1:0] r_div;

    // Free-running divider that wraps at the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == c_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign o_tick = (r_div == c_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Brief    : Multiplexed seven-segment scanner. Holds a DIGITS-nibble hex
//            value, steps one digit per SCAN_DIV cycles, presents the nibble
//            to the registered hex-to-segment converter and drives the
//            matching active-low digit enables one cycle later so both land
//            on the same edge. Optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIGITS   = SEG_DIGITS,
    parameter int SCAN_DIV = SEG_SCAN_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_en,
    output logic [3:0]            nib,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame
);

    localparam int                 c_IDX_W    = idx_width(DIGITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_DIG_OFF  = {DIGITS{~DIG_ACTIVE_LEVEL}};

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_blank;
    logic [3:0]            w_nib;
    logic [DIGITS-1:0]     w_sel;

    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    r_idx_d;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_disp;
    logic [3:0]            r_nib;
    logic                  r_blank;
    logic [DIGITS-1:0]     r_dig_n;
    logic                  r_frame;

    seg_scan_prescaler #(
        .TERMINAL (SCAN_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // A frame ends on the tick that leaves the last digit slot
    assign w_boundary = w_tick && (r_idx == c_LAST_IDX);

    // Digit index advances once per slot and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
        end
    end

    // Loads land in the shadow; the display copy only changes between frames
    // so a frame never shows a mix of old and new digits. A load on the
    // boundary cycle bypasses the shadow so it is not lost for a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            if (load) begin
                r_shadow <= value;
            end
            if (w_boundary) begin
                r_disp <= load ? value : r_shadow;
            end
        end
    end

    // Current digit is blank when it and every more significant nibble is zero
    always_comb begin
        logic w_nz_above;
        w_blank    = 1'b0;
        w_nz_above = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (r_disp[4*k +: 4] != 4'h0) begin
                w_nz_above = 1'b1;
            end
            if (c_IDX_W'(k) == r_idx) begin
                w_blank = lz_en && (k != 0) && !w_nz_above;
            end
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];
    assign w_sel = DIGITS'(1) << r_idx_d;

    // Output stage: nibble now, enable one cycle later to match the converter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib   <= 4'h0;
            r_blank <= 1'b1;
            r_idx_d <= '0;
            r_dig_n <= c_DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_nib   <= w_nib;
            r_blank <= w_blank;
            r_idx_d <= r_idx;
            r_dig_n <= r_blank ? c_DIG_OFF : (w_sel ^ c_DIG_OFF);
            r_frame <= w_boundary;
        end
    end

    assign nib   = r_nib;
    assign dig_n = r_dig_n;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan
// Brief    : Directed self-checking bench for seg_scan with DIGITS=4 and
//            SCAN_DIV=4. cyc counts rising edges since the last reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  nib;
    logic [3:0]  dig_n;
    logic        frame;

    int n_assert;
    int n_fail;
    int cyc;

    // Digit enable sequence with nothing blanked, indexed by (cyc-2)%16
    localparam logic [63:0] c_DIG_ALL  = 64'h7777_BBBB_DDDD_EEEE;
    // Digits 2 and 3 blanked
    localparam logic [63:0] c_DIG_LZ2  = 64'hFFFF_FFFF_DDDD_EEEE;
    // Only digit 0 enabled
    localparam logic [63:0] c_DIG_LZ1  = 64'hFFFF_FFFF_FFFF_EEEE;

    seg_scan #(
        .DIGITS   (4),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .lz_en (lz_en),
        .nib   (nib),
        .dig_n (dig_n),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One rising edge, sample 1 time unit later, enable-pattern sanity check
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("dig_n_onehot_or_blank", 16'($countones(~dig_n) <= 1), 16'd1);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // Step to cycle 'last' checking nib/dig_n/frame against 16-slot tables
    task automatic run_window(input int last, input logic [63:0] nt,
                              input logic [63:0] dt, input int dig_from);
        logic [3:0] e_nib;
        logic [3:0] e_dig;
        while (cyc < last) begin
            step();
            e_nib = nt[4*((cyc-1)%16) +: 4];
            e_dig = dt[4*((cyc-2)%16) +: 4];
            chk("nib", 16'(nib), 16'(e_nib));
            if (cyc >= dig_from) chk("dig_n", 16'(dig_n), 16'(e_dig));
            chk("frame", 16'(frame), 16'((cyc % 16) == 0));
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        lz_en    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_nib",   16'(nib),   16'h0);
        chk("reset_dig_n", 16'(dig_n), 16'hF);
        chk("reset_frame", 16'(frame), 16'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Idle scan: first edge still blank, then 1110,1101,1011,0111
        step();
        chk("first_edge_dig_n", 16'(dig_n), 16'hF);
        chk("first_edge_nib",   16'(nib),   16'h0);
        run_window(17, 64'h0, c_DIG_ALL, 2);

        // Load 1A3F mid-frame; shows from the frame after the boundary
        value = 16'h1A3F;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step_to(32);
        chk("boundary_frame", 16'(frame), 16'h1);
        chk("boundary_old_nib", 16'(nib), 16'h0);
        run_window(48, 64'h1111_AAAA_3333_FFFF, c_DIG_ALL, 34);

        // Leading-zero blanking with 00A5
        lz_en = 1'b1;
        value = 16'h00A5;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step_to(64);
        run_window(81, 64'h0000_0000_AAAA_5555, c_DIG_LZ2, 66);

        // Value 0 with blanking: only digit 0 lit, showing 0
        value = 16'h0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step_to(97);
        run_window(103, 64'h0, c_DIG_LZ1, 98);

        // 1111 mid-frame, then 2222 on the boundary tick cycle
        value = 16'h1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step_to(108);
        chk("no_midframe_update", 16'(nib), 16'h0);
        step_to(111);
        value = 16'h2222;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("tearfree_frame", 16'(frame), 16'h1);
        chk("tearfree_old_nib", 16'(nib), 16'h0);
        run_window(129, 64'h2222_2222_2222_2222, c_DIG_ALL, 114);

        // Asynchronous reset during the digit 2 slot
        step_to(139);
        chk("slot2_dig_n", 16'(dig_n), 16'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dig_n", 16'(dig_n), 16'hF);
        chk("async_rst_nib",   16'(nib),   16'h0);
        chk("async_rst_frame", 16'(frame), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_dig_n", 16'(dig_n), 16'hF);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("restart_first_dig_n", 16'(dig_n), 16'hF);
        chk("restart_first_nib",   16'(nib),   16'h0);
        run_window(20, 64'h0, c_DIG_LZ1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Multiplexed seven-segment display scanner that sits directly upstream of the registered hex-to-segment converter. It holds a multi-digit hexadecimal value (typically the current TLC5620 DAC code), steps through the digits at a divided rate, and presents one 4-bit nibble per digit slot to the converter. It drives the matching active-low digit enables, delayed to line up with the converter's one-cycle registered latency, with optional leading-zero blanking.

## Interface
- DIGITS, 4, number of display digits; value width is 4*DIGITS.
- SCAN_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; captures value.
- value  input  4*DIGITS  hex value to display; digit 0 = bits [3:0], least significant.
- lz_en  input  1  1 = blank leading zero digits (digit 0 never blanked).
- nib  output  4  nibble for current digit; feeds the converter's i input.
- dig_n  output  DIGITS  one-hot active-low digit enable; all 1 = blank.
- frame  output  1  one-cycle pulse when the scan index wraps from DIGITS-1 to 0.

## Operation
- Registers: prescaler div (width clog2(SCAN_DIV)), digit index idx (width clog2(DIGITS), min 1), shadow, disp (4*DIGITS each), nib, dig_n, an internal blank flag, frame.
- Reset values:
  - div = 0, idx = 0, shadow = 0, disp = 0.
  - nib = 0, dig_n = all 1, frame = 0.
- Prescaler: div counts 0..SCAN_DIV-1 and wraps. tick = (div == SCAN_DIV-1).
- On tick, idx advances by 1. It wraps from DIGITS-1 to 0. Non-power-of-two DIGITS never reaches indices ≥ DIGITS.
- Value capture:
  - load writes value into shadow in the same edge.
  - disp copies shadow only at a frame boundary (tick with idx == DIGITS-1). This gives tear-free updates.
  - If load coincides with the boundary, disp takes value directly. shadow also takes value.
- Multiple loads within one frame: the last one wins.
- Blanking: digit k is blank when lz_en = 1, k ≠ 0, and all disp nibbles k..DIGITS-1 are zero. Value 0 with lz_en shows a single "0" on digit 0.
- Output stage:
  - Every cycle, nib <= disp nibble [idx] and blank <= blank(idx).
  - dig_n <= blank ? all 1 : ~(1 << idx_d), where idx_d is idx registered alongside nib. dig_n therefore lags nib by exactly one cycle, matching the converter's output register.
- frame: registered, asserted for the one cycle following the boundary tick.
- Reset mid-scan: all registers return to reset values immediately. Display blank until the second cycle after release.

## Timing
- Edge N: tick with idx = k. Edge N+1: idx = k+1. Edge N+2: nib = disp[k+1]. Edge N+3: converter o valid for k+1 and dig_n selects k+1. Segments and enable change on the same edge.
- Each digit is enabled for exactly SCAN_DIV cycles. Full frame = DIGITS*SCAN_DIV cycles.
- load-to-display latency: up to one frame plus 3 cycles. It is never applied mid-frame.
- No backpressure; load accepted every cycle.

## Structure
- Shared package: SEG_DIGITS default, scan-rate constant SCAN_DIV derived from board clock, digit-enable polarity constant. The converter and this block reference the same DIGITS constant.
- One natural sub-module: scan_prescaler (parameterised terminal-count divider emitting tick). The rest stays flat.
- Top level instantiates seg_scan → Convert, with nib → i and dig_n/o to pins.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.
- Reset released, no load → nib = 0 each slot. dig_n cycles 1110, 1101, 1011, 0111, each held 4 cycles. First dig_n change is 1 cycle after nib.
- load value=16'h1A3F, lz_en=0 → after the next frame, nib sequence F, 3, A, 1 on digits 0..3. frame pulses every 16 cycles.
- load 16'h00A5, lz_en=1 → digits 2 and 3 have dig_n all 1 in their slots. Digits 0/1 show 5, A. value 16'h0000 → only digit 0 is enabled, with nib 0.
- load 16'h1111 at mid-frame, then 16'h2222 on the boundary tick cycle → displayed frame is all 2, never a mix of 1 and 2.
- Assert rst_n low during digit 2 slot → dig_n = 1111, nib = 0, idx = 0 asynchronously. After release, the scan restarts at digit 0.
- Check dig_n one-hot or all-ones every cycle, and check dig_n always lags idx by 2 cycles.
